fixed_point_op_sequencer: RTL and testbench

Parametrised fixed-point register machine that executes a stream of operations, one at a time, against a DEPTH-entry register file of N-bit, Q-fractional-bit two's-complement values. Instructions arrive over a valid/ready handshake. Multiply is a multi-cycle operation with stall. Overflow handling is selectable: saturate or wrap. Sits between the equation-schedule generator and the neuron-update datapath, replacing the single-cycle hardcoded operation machine for state-variable updates.

---
 rtl/fixed_point_op_sequencer_if.sv | 28 ++
 rtl/fixed_point_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_fixed_point_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_op_sequencer_if.sv
// Instruction and result bundle for fixed_point_op_sequencer.
// The master side issues instructions; the slave side is the sequencer.
interface fixed_point_op_sequencer_if #(
    parameter int N  = 32,
    parameter int AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [AW-1:0] dst;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic [N-1:0]  imm;
    logic [N-1:0]  result;
    logic          result_valid;
    logic          overflow;
    logic          err;

    modport master (
        output instr_valid, opcode, dst, src_a, src_b, imm,
        input  instr_ready, result, result_valid, overflow, err
    );

    modport slave (
        input  instr_valid, opcode, dst, src_a, src_b, imm,
        output instr_ready, result, result_valid, overflow, err
    );
endinterface

// File: rtl/fixed_point_op_sequencer.sv
// Fixed-point register machine: one instruction at a time against a small register file,
// multi-cycle multiply with stall, saturating or wrapping overflow.
module fixed_point_op_sequencer #(
    parameter int N        = 32,
    parameter int Q        = 16,
    parameter int DEPTH    = 8,
    parameter int MUL_LAT  = 2,
    parameter int SATURATE = 1
) (
    input logic clk,
    input logic rst,
    fixed_point_op_sequencer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_NEG  = 4'd6;
    localparam logic [3:0] OP_ABS  = 4'd7;
    localparam logic [3:0] OP_OUT  = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;

    localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic signed [N-1:0]   regs [DEPTH];
    logic signed [N-1:0]   mul_a, mul_b;
    logic [AW-1:0]         mul_dst;

    logic                  accept;
    logic signed [N-1:0]   rd_a, rd_b;
    logic signed [N:0]     sum_ab, diff_ab, neg_a, ext_a;
    logic [N:0]            alu_res;     // {overflow, value}
    logic                  wr_en, use_d, use_a, use_b, illegal, bad;
    logic signed [2*N-1:0] prod, shifted;
    logic                  mul_ovf;
    logic [N-1:0]          mul_val;

    function automatic logic idx_ok(input logic [AW-1:0] i);
        return 32'(i) < 32'(DEPTH);
    endfunction

    // Reduce an N+1 bit result to N bits, flagging and clamping/wrapping on overflow.
    function automatic logic [N:0] fit(input logic [N:0] v);
        logic ovf;
        ovf = v[N] ^ v[N-1];
        if (ovf && SATURATE != 0)
            return {1'b1, v[N] ? MIN_V : MAX_V};
        return {ovf, v[N-1:0]};
    endfunction

    assign bus.instr_ready = (state == ST_IDLE) & ~rst;
    assign accept          = bus.instr_valid & bus.instr_ready;

    assign rd_a    = idx_ok(bus.src_a) ? regs[bus.src_a] : '0;
    assign rd_b    = idx_ok(bus.src_b) ? regs[bus.src_b] : '0;
    assign ext_a   = {rd_a[N-1], rd_a};
    assign sum_ab  = ext_a + {rd_b[N-1], rd_b};
    assign diff_ab = ext_a - {rd_b[N-1], rd_b};
    assign neg_a   = -ext_a;

    always_comb begin
        alu_res = '0;
        wr_en   = 1'b0;
        use_d   = 1'b0;
        use_a   = 1'b0;
        use_b   = 1'b0;
        illegal = 1'b0;
        case (bus.opcode)
            OP_NOP:  ;
            OP_LOAD: begin use_d = 1'b1; wr_en = 1'b1; alu_res = {1'b0, bus.imm}; end
            OP_MOV:  begin use_d = 1'b1; use_a = 1'b1; wr_en = 1'b1; alu_res = {1'b0, rd_a}; end
            OP_ADD:  begin use_d = 1'b1; use_a = 1'b1; use_b = 1'b1; wr_en = 1'b1; alu_res = fit(sum_ab); end
            OP_SUB:  begin use_d = 1'b1; use_a = 1'b1; use_b = 1'b1; wr_en = 1'b1; alu_res = fit(diff_ab); end
            OP_MUL:  begin use_d = 1'b1; use_a = 1'b1; use_b = 1'b1; end
            OP_NEG:  begin use_d = 1'b1; use_a = 1'b1; wr_en = 1'b1; alu_res = fit(neg_a); end
            OP_ABS:  begin use_d = 1'b1; use_a = 1'b1; wr_en = 1'b1; alu_res = fit(rd_a[N-1] ? neg_a : ext_a); end
            OP_OUT:  use_a = 1'b1;
            OP_CLR:  ;
            default: illegal = 1'b1;
        endcase
        bad = illegal | (use_d & ~idx_ok(bus.dst)) | (use_a & ~idx_ok(bus.src_a))
                      | (use_b & ~idx_ok(bus.src_b));
    end

    // Product of the captured operands; the shifted value must sign-extend from bit N-1 to fit.
    assign prod    = mul_a * mul_b;
    assign shifted = prod >>> Q;
    assign mul_ovf = ~((&shifted[2*N-1:N-1]) | ~(|shifted[2*N-1:N-1]));
    assign mul_val = (mul_ovf && SATURATE != 0) ? (shifted[2*N-1] ? MIN_V : MAX_V)
                                                : shifted[N-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            mul_a            <= '0;
            mul_b            <= '0;
            mul_dst          <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.err          <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            bus.err <= 1'b1;
                        end else if (bus.opcode == OP_CLR) begin
                            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
                            bus.overflow <= 1'b0;
                            bus.err      <= 1'b0;
                        end else if (bus.opcode == OP_MUL) begin
                            mul_a   <= rd_a;
                            mul_b   <= rd_b;
                            mul_dst <= bus.dst;
                            cnt     <= CW'(MUL_LAT);
                            state   <= ST_MUL_BUSY;
                        end else begin
                            if (wr_en) begin
                                regs[bus.dst] <= alu_res[N-1:0];
                                bus.overflow  <= bus.overflow | alu_res[N];
                            end
                            if (bus.opcode == OP_OUT) begin
                                bus.result       <= rd_a;
                                bus.result_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        regs[mul_dst] <= mul_val;
                        bus.overflow  <= bus.overflow | mul_ovf;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_op_sequencer.sv
// Bench for fixed_point_op_sequencer: a saturating DEPTH=8 build and a wrapping DEPTH=6 build
// run the same instruction stream, each checked against an integer-arithmetic model.
module tb_fixed_point_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_point_op_sequencer_if #(.N(32), .AW(3)) bus0 ();
    fixed_point_op_sequencer_if #(.N(32), .AW(3)) bus1 ();

    fixed_point_op_sequencer #(.N(32), .Q(16), .DEPTH(8), .MUL_LAT(2), .SATURATE(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fixed_point_op_sequencer #(.N(32), .Q(16), .DEPTH(6), .MUL_LAT(2), .SATURATE(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    int n_chk = 0;
    int n_bad = 0;
    int sat_m [2] = '{1, 0};
    int dep_m [2] = '{8, 6};
    logic [31:0] m_reg [2][8];
    logic        m_ovf [2];
    logic        m_err [2];
    logic        m_rv  [2];
    logic [31:0] m_res [2];
    int          last_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
            m_ovf[k] = 1'b0; m_err[k] = 1'b0; m_rv[k] = 1'b0; m_res[k] = '0;
        end
    endfunction

    function automatic logic [31:0] m_fit(input int k, input longint v);
        if (v > MAXV || v < MINV) begin
            m_ovf[k] = 1'b1;
            if (sat_m[k] != 0) return (v > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        return v[31:0];
    endfunction

    function automatic void m_apply(input int k, input int op, input int d, input int a,
                                    input int b, input logic [31:0] im);
        longint va, vb;
        bit ud, ua, ub;
        va = longint'($signed(m_reg[k][a]));
        vb = longint'($signed(m_reg[k][b]));
        ud = op inside {1, 2, 3, 4, 5, 6, 7};
        ua = op inside {2, 3, 4, 5, 6, 7, 8};
        ub = op inside {3, 4, 5};
        if (op > 9 || (ud && d >= dep_m[k]) || (ua && a >= dep_m[k]) || (ub && b >= dep_m[k])) begin
            m_err[k] = 1'b1;
            return;
        end
        case (op)
            1: m_reg[k][d] = im;
            2: m_reg[k][d] = m_reg[k][a];
            3: m_reg[k][d] = m_fit(k, va + vb);
            4: m_reg[k][d] = m_fit(k, va - vb);
            5: m_reg[k][d] = m_fit(k, (va * vb) >>> 16);
            6: m_reg[k][d] = m_fit(k, -va);
            7: m_reg[k][d] = m_fit(k, (va < 0) ? -va : va);
            8: begin m_res[k] = m_reg[k][a]; m_rv[k] = 1'b1; end
            9: begin
                for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
                m_ovf[k] = 1'b0; m_err[k] = 1'b0;
            end
            default: ;
        endcase
    endfunction

    task automatic check_dut(input int k);
        logic rdy, rv, ov, er;
        logic [31:0] res;
        if (k == 0) begin
            rdy = bus0.instr_ready; rv = bus0.result_valid; ov = bus0.overflow;
            er = bus0.err; res = bus0.result;
        end else begin
            rdy = bus1.instr_ready; rv = bus1.result_valid; ov = bus1.overflow;
            er = bus1.err; res = bus1.result;
        end
        chk($sformatf("result_valid%0d", k), rv, m_rv[k]);
        if (rdy) begin
            chk($sformatf("result%0d", k), res, m_res[k]);
            chk($sformatf("overflow%0d", k), ov, m_ovf[k]);
            chk($sformatf("err%0d", k), er, m_err[k]);
        end
    endtask

    // Present one instruction to both builds; each accepts it when its own ready allows.
    task automatic issue(input int op, input int d, input int a, input int b, input logic [31:0] im);
        bit done0 = 0, done1 = 0, acc0, acc1;
        int cyc = 0;
        bus0.opcode = 4'(op); bus0.dst = 3'(d); bus0.src_a = 3'(a); bus0.src_b = 3'(b); bus0.imm = im;
        bus1.opcode = 4'(op); bus1.dst = 3'(d); bus1.src_a = 3'(a); bus1.src_b = 3'(b); bus1.imm = im;
        while (!(done0 && done1) && cyc < 20) begin
            bus0.instr_valid = !done0;
            bus1.instr_valid = !done1;
            #1;
            acc0 = !done0 && bus0.instr_ready;
            acc1 = !done1 && bus1.instr_ready;
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            @(posedge clk);
            if (acc0) begin m_apply(0, op, d, a, b, im); done0 = 1; end
            if (acc1) begin m_apply(1, op, d, a, b, im); done1 = 1; end
            @(negedge clk);
            check_dut(0);
            check_dut(1);
            cyc++;
        end
        chk("accept_in_time", {30'd0, done0, done1}, 32'd3);
        last_wait = cyc;
        bus0.instr_valid = 1'b0;
        bus1.instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            @(negedge clk);
            check_dut(0);
            check_dut(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lo;
        int op, r;
        logic [31:0] im;
        bus0.instr_valid = 0; bus0.opcode = 0; bus0.dst = 0; bus0.src_a = 0; bus0.src_b = 0; bus0.imm = 0;
        bus1.instr_valid = 0; bus1.opcode = 0; bus1.dst = 0; bus1.src_a = 0; bus1.src_b = 0; bus1.imm = 0;
        m_reset();
        #1;
        chk("rst_ready0", bus0.instr_ready, 0);
        chk("rst_ready1", bus1.instr_ready, 0);
        chk("rst_result0", bus0.result, 0);
        chk("rst_rv0", bus0.result_valid, 0);
        chk("rst_ovf0", bus0.overflow, 0);
        chk("rst_err0", bus0.err, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", bus0.instr_ready, 1);
        chk("post_rst_ready1", bus1.instr_ready, 1);

        // 1.5 * 2.25 with a 2-cycle multiply stall
        issue(1, 1, 0, 0, 32'h0001_8000);
        issue(1, 2, 0, 0, 32'h0002_4000);
        issue(5, 3, 1, 2, 32'h0);
        lo = 0;
        while (!bus0.instr_ready && lo < 10) begin
            lo++;
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            @(negedge clk);
            check_dut(0); check_dut(1);
        end
        chk("mul_stall_cycles", lo, 2);
        issue(8, 0, 3, 0, 32'h0);
        chk("mul_result", bus0.result, 32'h0003_6000);
        chk("mul_rv", bus0.result_valid, 1);
        chk("mul_no_ovf", bus0.overflow, 0);

        // ADD overflow: saturate in build 0, wrap in build 1
        issue(9, 0, 0, 0, 32'h0);
        issue(1, 0, 0, 0, 32'h7FFF_0000);
        issue(1, 1, 0, 0, 32'h0002_0000);
        issue(3, 2, 0, 1, 32'h0);
        issue(8, 0, 2, 0, 32'h0);
        chk("add_sat", bus0.result, 32'h7FFF_FFFF);
        chk("add_wrap", bus1.result, 32'h8001_0000);
        chk("add_ovf0", bus0.overflow, 1);
        chk("add_ovf1", bus1.overflow, 1);

        // NEG/ABS of the most negative value, then an ordinary NEG
        issue(9, 0, 0, 0, 32'h0);
        issue(1, 3, 0, 0, 32'h8000_0000);
        issue(6, 4, 3, 0, 32'h0);
        issue(7, 5, 3, 0, 32'h0);
        issue(8, 0, 4, 0, 32'h0);
        chk("neg_min_sat", bus0.result, 32'h7FFF_FFFF);
        chk("neg_min_wrap", bus1.result, 32'h8000_0000);
        issue(8, 0, 5, 0, 32'h0);
        chk("abs_min_sat", bus0.result, 32'h7FFF_FFFF);
        chk("negabs_ovf0", bus0.overflow, 1);
        issue(1, 3, 0, 0, 32'hFFFF_0000);
        issue(6, 4, 3, 0, 32'h0);
        issue(8, 0, 4, 0, 32'h0);
        chk("neg_plain", bus0.result, 32'h0001_0000);

        // back-to-back single-cycle ops with forwarding through the register file
        issue(1, 1, 0, 0, 32'd5);
        chk("b2b_wait_load", last_wait, 1);
        issue(3, 1, 1, 1, 32'h0);
        chk("b2b_wait_add1", last_wait, 1);
        issue(3, 1, 1, 1, 32'h0);
        chk("b2b_wait_add2", last_wait, 1);
        issue(8, 0, 1, 0, 32'h0);
        chk("b2b_wait_out", last_wait, 1);
        chk("b2b_result", bus0.result, 32'd20);

        // illegal opcode, out-of-range index in the DEPTH=6 build, then CLR
        issue(9, 0, 0, 0, 32'h0);
        issue(1, 1, 0, 0, 32'h0000_1234);
        issue(12, 1, 2, 3, 32'h0);
        chk("illegal_err0", bus0.err, 1);
        chk("illegal_err1", bus1.err, 1);
        issue(2, 1, 7, 0, 32'h0);
        issue(8, 0, 1, 0, 32'h0);
        chk("oob_unchanged1", bus1.result, 32'h0000_1234);
        issue(8, 0, 7, 0, 32'h0);
        issue(9, 0, 0, 0, 32'h0);
        chk("clr_err0", bus0.err, 0);
        chk("clr_err1", bus1.err, 0);

        // reset in the first busy cycle of a multiply
        issue(1, 1, 0, 0, 32'h0003_0000);
        issue(1, 2, 0, 0, 32'h0002_0000);
        issue(5, 3, 1, 2, 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_mul_rst_ready0", bus0.instr_ready, 0);
        chk("mid_mul_rst_ready1", bus1.instr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        chk("mid_mul_rel_ready0", bus0.instr_ready, 1);
        chk("mid_mul_rel_ready1", bus1.instr_ready, 1);
        issue(8, 0, 3, 0, 32'h0);
        chk("mid_mul_no_write", bus0.result, 32'h0);
        issue(8, 0, 1, 0, 32'h0);
        chk("mid_mul_regs_clear", bus0.result, 32'h0);

        // randomized stream
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)      op = int'($urandom_range(10, 15));
            else if (r < 6) op = 9;
            else            op = int'($urandom_range(0, 8));
            im = $urandom;
            case ($urandom_range(0, 2))
                1: im = {{12{im[19]}}, im[19:0]};
                2: im = {im[31], {15{~im[31]}}, im[15:0]};
                default: ;
            endcase
            issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), im);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int i = 0; i < 8; i++) issue(8, 0, i, 0, 32'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
